// File: rtl/data_mem_sized_pkg.sv
// rtl/data_mem_sized_pkg.sv - shared size encodings and FSM states for the sized data memory
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_e;

endpackage

// File: rtl/data_mem_sized_if.sv
// rtl/data_mem_sized_if.sv - MEM-stage request/response bundle for the sized data memory
interface data_mem_sized_if;

  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        load_unsigned;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_valid;
  logic        fault;
  logic        busy;

  modport master (
    output mem_read, mem_write, size, load_unsigned, address, write_data,
    input  read_data, read_valid, fault, busy
  );

  modport slave (
    input  mem_read, mem_write, size, load_unsigned, address, write_data,
    output read_data, read_valid, fault, busy
  );

endinterface

// File: rtl/data_mem_sized_load_align.sv
// rtl/data_mem_sized_load_align.sv - right-justify and extend the addressed lanes of a word
module mem_load_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        load_unsigned_i,
  output logic [31:0] result_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = word_i >> {offset_i, 3'b000};
    result_o = shifted;
    case (size_i)
      SZ_BYTE: result_o = load_unsigned_i ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = load_unsigned_i ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_sized.sv
// rtl/data_mem_sized.sv - byte-addressable MEM-stage data memory with sub-word access,
// fault detection and a post-reset zero-fill sequence
module data_mem_sized
  import data_mem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int IDX_W          = $clog2(DEPTH),
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  data_mem_sized_if.slave   bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]        read_data_q, read_data_d;
  logic               read_valid_q, read_valid_d;
  logic               fault_q, fault_d;

  logic [31:0]        mem_q [DEPTH];

  logic [1:0]         offset;
  logic [IDX_W-1:0]   widx;
  logic               out_of_range;
  logic               misaligned;
  logic               req_fault;
  logic               ready;
  logic               store_fire;
  logic               load_fire;
  logic [31:0]        aligned;

  logic               mem_we;
  logic [IDX_W-1:0]   mem_widx;
  logic [31:0]        mem_wdata;
  logic [3:0]         mem_be;

  // Request decode
  always_comb begin
    offset       = bus.address[1:0];
    widx         = bus.address[IDX_W+1:2];
    out_of_range = (bus.address >> (IDX_W + 2)) != 32'd0;
    case (bus.size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = bus.address[0];
      SZ_WORD: misaligned = (bus.address[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
    req_fault  = out_of_range | misaligned;
    ready      = (state_q == ST_READY);
    store_fire = ready & bus.mem_write;
    load_fire  = ready & bus.mem_read & ~bus.mem_write;
  end

  mem_load_align u_align (
    .word_i          (mem_q[widx]),
    .offset_i        (offset),
    .size_i          (bus.size),
    .load_unsigned_i (bus.load_unsigned),
    .result_o        (aligned)
  );

  // FSM next state, clear counter and the single write port shared by clear and stores
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    mem_we    = 1'b0;
    mem_widx  = widx;
    mem_wdata = bus.write_data;
    mem_be    = 4'h0;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx_q;
        mem_wdata = 32'h0;
        mem_be    = 4'hF;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      default: begin
        mem_we = store_fire & ~req_fault;
        case (bus.size)
          SZ_BYTE: begin
            mem_be    = 4'b0001 << offset;
            mem_wdata = {4{bus.write_data[7:0]}};
          end
          SZ_HALF: begin
            mem_be    = 4'b0011 << offset;
            mem_wdata = {2{bus.write_data[15:0]}};
          end
          default: mem_be = 4'hF;
        endcase
      end
    endcase
  end

  always_comb begin
    read_valid_d = load_fire;
    fault_d      = (store_fire | load_fire) & req_fault;
    read_data_d  = read_data_q;
    if (load_fire) begin
      read_data_d = req_fault ? 32'h0 : aligned;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_idx_q    <= '0;
      read_data_q  <= 32'h0;
      read_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      fault_q      <= fault_d;
    end
  end

  // Storage array carries no reset; the clear sequence provides known contents
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) begin
          mem_q[mem_widx][8*l +: 8] <= mem_wdata[8*l +: 8];
        end
      end
    end
  end

  assign bus.read_data  = read_data_q;
  assign bus.read_valid = read_valid_q;
  assign bus.fault      = fault_q;
  assign bus.busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_data_mem_sized.sv
// tb/tb_data_mem_sized.sv - directed self-checking bench for data_mem_sized (DEPTH = 16)
module tb_data_mem_sized;
  import data_mem_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_busy;

  data_mem_sized_if bus ();

  data_mem_sized #(
    .DEPTH          (16),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.size          = SZ_WORD;
    bus.load_unsigned = 1'b0;
    bus.address       = 32'h0;
    bus.write_data    = 32'h0;
  endtask

  // Drive one request for one edge; outputs are stable for the caller at posedge+1
  task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus.mem_read      = rd;
    bus.mem_write     = wr;
    bus.size          = sz;
    bus.load_unsigned = uns;
    bus.address       = addr;
    bus.write_data    = wd;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  // Count edges until busy falls; optionally hammer requests that must be ignored
  task automatic count_busy(output int n, input bit stim);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (stim) begin
        bus.mem_read   = i[0];
        bus.mem_write  = ~i[0];
        bus.size       = SZ_WORD;
        bus.address    = 32'h0;
        bus.write_data = 32'h1234_5678;
      end
      @(posedge clk);
      #1;
      n++;
      if (stim) begin
        check("busy_rv", {31'h0, bus.read_valid}, 32'h0);
        check("busy_fault", {31'h0, bus.fault}, 32'h0);
      end
      if (!bus.busy) break;
    end
    set_idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    set_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, bus.busy}, 32'h1);
    check("rst_rv", {31'h0, bus.read_valid}, 32'h0);
    check("rst_fault", {31'h0, bus.fault}, 32'h0);
    check("rst_rdata", bus.read_data, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    count_busy(n_busy, 1'b0);
    check("clear_len", n_busy, 32'd16);

    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h3C, 32'h0);
    check("lw3c_rv", {31'h0, bus.read_valid}, 32'h1);
    check("lw3c_data", bus.read_data, 32'h0);

    do_req(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h1122_3344);
    check("sw8_rv", {31'h0, bus.read_valid}, 32'h0);
    check("sw8_fault", {31'h0, bus.fault}, 32'h0);
    do_req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'hB, 32'h0);
    check("lbB_rv", {31'h0, bus.read_valid}, 32'h1);
    check("lbB_data", bus.read_data, 32'h0000_0011);
    do_req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h8, 32'h0);
    check("lb8_data", bus.read_data, 32'h0000_0044);
    do_req(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h9, 32'h0000_00F0);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    check("lw8_after_sb", bus.read_data, 32'h1122_F044);
    do_req(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h9, 32'h0);
    check("lb9_sext", bus.read_data, 32'hFFFF_FFF0);

    do_req(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h4, 32'h0000_8001);
    do_req(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h4, 32'h0);
    check("lh4_data", bus.read_data, 32'hFFFF_8001);
    do_req(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h4, 32'h0);
    check("lhu4_data", bus.read_data, 32'h0000_8001);

    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h6, 32'h0);
    check("lw6_fault", {31'h0, bus.fault}, 32'h1);
    check("lw6_rv", {31'h0, bus.read_valid}, 32'h1);
    check("lw6_data", bus.read_data, 32'h0);
    do_req(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h5, 32'h0000_AAAA);
    check("sh5_fault", {31'h0, bus.fault}, 32'h1);
    check("sh5_rv", {31'h0, bus.read_valid}, 32'h0);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0);
    check("lw4_unchanged", bus.read_data, 32'h0000_8001);
    check("lw4_nofault", {31'h0, bus.fault}, 32'h0);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0);
    check("lw40_fault", {31'h0, bus.fault}, 32'h1);
    check("lw40_data", bus.read_data, 32'h0);
    do_req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("illegal_size_fault", {31'h0, bus.fault}, 32'h1);

    do_req(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF);
    check("rw_rv", {31'h0, bus.read_valid}, 32'h0);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    check("lw0_rv", {31'h0, bus.read_valid}, 32'h1);
    check("lw0_data", bus.read_data, 32'hDEAD_BEEF);
    do_req(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    check("idle_rv", {31'h0, bus.read_valid}, 32'h0);
    check("idle_hold", bus.read_data, 32'hDEAD_BEEF);

    // Restart the clear part way through, then confirm requests during busy are dropped
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n_busy, 1'b1);
    check("restart_len", n_busy, 32'd16);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    check("post_clear_rv", {31'h0, bus.read_valid}, 32'h1);
    check("post_clear_lw0", bus.read_data, 32'h0);
    do_req(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0);
    check("post_clear_lw8", bus.read_data, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
